ps2_host_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_host_rx_if.sv | 24 ++
 rtl/ps2_line_filter.sv | 46 ++++
 rtl/ps2_host_rx.sv | 139 +++++++++++++
 tb/tb_ps2_host_rx.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame geometry, FSM state encoding and the odd-parity helper.
// Used by both the host receiver and the device-side transmitter.
package ps2_pkg;

   localparam int unsigned FRAME_BITS = 11;
   localparam int unsigned DATA_BITS  = 8;

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StParity,
      StStop
   } ps2_state_e;

   // Parity bit that makes the 8 data bits plus parity contain an odd number of ones
   function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_host_rx_if.sv
// Host receiver bus: PS/2 line inputs plus the fabric-side byte/status outputs.
// master = receiver side, slave = line driver / consumer side.
interface ps2_host_rx_if;
   import ps2_pkg::*;

   logic                 ps2clk;
   logic                 ps2data;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 parity_err;
   logic                 frame_err;
   logic                 busy;

   modport master (
      input  ps2clk, ps2data,
      output data_out, data_valid, parity_err, frame_err, busy
   );

   modport slave (
      output ps2clk, ps2data,
      input  data_out, data_valid, parity_err, frame_err, busy
   );

endinterface

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer, FILTER_LEN-cycle glitch filter and registered falling-edge pulse
// for one asynchronous PS/2 line. All flops idle high, matching the bus idle level.
module ps2_line_filter #(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic line,
   output logic level,
   output logic fall
);

   localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);

   logic [1:0]      sync_q;
   logic            level_q;
   logic            fall_q;
   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= 2'b11;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q <= {sync_q[0], line};
         fall_q <= 1'b0;
         if (sync_q[1] == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CntMax) begin
            // FILTER_LEN consecutive cycles at the new level: commit it
            level_q <= sync_q[1];
            fall_q  <= level_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + CntW'(1);
         end
      end
   end

   assign level = level_q;
   assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_rx.sv
// Host-side PS/2 receiver: deframes start/8 data/odd parity/stop frames from the device,
// emits one-cycle data_valid / parity_err / frame_err pulses, abandons stalled frames.
module ps2_host_rx
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN  = 8,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input logic           clk,
   input logic           rst,
   ps2_host_rx_if.master bus
);

   localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

   logic clk_fall;
   logic data_lvl;
   logic clk_level_unused;
   logic data_fall_unused;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk   (clk),
      .rst   (rst),
      .line  (bus.ps2clk),
      .level (clk_level_unused),
      .fall  (clk_fall)
   );

   // Data only needs synchronizing; it is stable around the clock fall
   ps2_line_filter #(.FILTER_LEN(1)) u_data_sync (
      .clk   (clk),
      .rst   (rst),
      .line  (bus.ps2data),
      .level (data_lvl),
      .fall  (data_fall_unused)
   );

   ps2_state_e           state_q, state_d;
   logic [2:0]           bitcnt_q, bitcnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_q, par_d;
   logic [TmoW-1:0]      tmo_q, tmo_d;
   logic [DATA_BITS-1:0] dout_q, dout_d;
   logic                 dv_q, dv_d;
   logic                 pe_q, pe_d;
   logic                 fe_q, fe_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         bitcnt_q <= '0;
         shreg_q  <= '0;
         par_q    <= 1'b0;
         tmo_q    <= '0;
         dout_q   <= '0;
         dv_q     <= 1'b0;
         pe_q     <= 1'b0;
         fe_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shreg_q  <= shreg_d;
         par_q    <= par_d;
         tmo_q    <= tmo_d;
         dout_q   <= dout_d;
         dv_q     <= dv_d;
         pe_q     <= pe_d;
         fe_q     <= fe_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shreg_d  = shreg_q;
      par_d    = par_q;
      dout_d   = dout_q;
      dv_d     = 1'b0;
      pe_d     = 1'b0;
      fe_d     = 1'b0;

      if (state_q == StIdle || clk_fall) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + TmoW'(1);
      end

      case (state_q)
         StIdle: begin
            if (clk_fall && !data_lvl) begin
               state_d  = StData;
               bitcnt_d = '0;
            end
         end
         StData: begin
            if (clk_fall) begin
               shreg_d[bitcnt_q] = data_lvl;
               bitcnt_d          = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
                  state_d = StParity;
               end
            end
         end
         StParity: begin
            if (clk_fall) begin
               par_d   = data_lvl;
               state_d = StStop;
            end
         end
         StStop: begin
            if (clk_fall) begin
               pe_d    = (par_q != odd_parity(shreg_q));
               fe_d    = !data_lvl;
               state_d = StIdle;
               if (par_q == odd_parity(shreg_q) && data_lvl) begin
                  dv_d   = 1'b1;
                  dout_d = shreg_q;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Stalled frame: no clock fall for TIMEOUT_CYC cycles
      if (state_q != StIdle && !clk_fall && tmo_q == TmoLast) begin
         state_d = StIdle;
         fe_d    = 1'b1;
         tmo_d   = '0;
      end
   end

   assign bus.data_out   = dout_q;
   assign bus.data_valid = dv_q;
   assign bus.parity_err = pe_q;
   assign bus.frame_err  = fe_q;
   assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_host_rx.sv
// Self-checking bench for ps2_host_rx: a behavioural PS/2 device drives directed and random
// frames; outcomes are predicted from the frame contents and compared with assertions.
module tb_ps2_host_rx;

   localparam int unsigned F    = 8;
   localparam int unsigned T    = 1000;
   localparam int unsigned HALF = 30;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ps2_host_rx_if bus();

   ps2_host_rx #(.FILTER_LEN(F), .TIMEOUT_CYC(T)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Pulse monitor
   int         cyc    = 0;
   int         n_dv   = 0;
   int         n_pe   = 0;
   int         n_fe   = 0;
   int         dv_cyc = 0;
   int         fe_cyc = 0;
   logic [7:0] dv_bytes[$];

   always @(negedge clk) begin
      cyc++;
      if (bus.data_valid === 1'b1) begin
         n_dv++;
         dv_cyc = cyc;
         dv_bytes.push_back(bus.data_out);
      end
      if (bus.parity_err === 1'b1) n_pe++;
      if (bus.frame_err === 1'b1) begin
         n_fe++;
         fe_cyc = cyc;
      end
   end

   int         n_cmp = 0;
   int         n_err = 0;
   int         b_dv, b_pe, b_fe;
   int         fall_cyc;
   logic [7:0] exp_dout;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_range(input string tag, input int val, input int lo, input int hi);
      n_cmp++;
      assert (val >= lo && val <= hi) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic snap();
      b_dv = n_dv;
      b_pe = n_pe;
      b_fe = n_fe;
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] b, input logic p, input logic s);
      return {s, p, b, 1'b0};
   endfunction

   // Correct odd parity from a count of ones
   function automatic logic good_par(input logic [7:0] b);
      return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
   endfunction

   // Device drives frame bits first..last; bit glitch gets a short low clock glitch with
   // the data line temporarily inverted
   task automatic drive_bits(input logic [10:0] fr, input int first, input int last,
                             input int glitch);
      for (int i = first; i <= last; i++) begin
         @(negedge clk);
         bus.ps2data = fr[i];
         if (i == glitch) begin
            idle(8);
            bus.ps2data = ~fr[i];
            bus.ps2clk  = 1'b0;
            idle(F - 1);
            bus.ps2clk  = 1'b1;
            idle(4);
            bus.ps2data = fr[i];
            idle(HALF - 12 - (F - 1));
         end else begin
            idle(HALF);
         end
         bus.ps2clk = 1'b0;
         fall_cyc   = cyc;
         idle(HALF);
         bus.ps2clk = 1'b1;
      end
   endtask

   task automatic expect_frame(input string tag, input logic [7:0] b, input logic p,
                               input logic s);
      logic ok;
      ok = (($countones(b) + p) % 2 == 1);
      idle(40);
      check({tag, ".dv"}, n_dv - b_dv, (ok && s) ? 1 : 0);
      check({tag, ".pe"}, n_pe - b_pe, ok ? 0 : 1);
      check({tag, ".fe"}, n_fe - b_fe, s ? 0 : 1);
      if (ok && s) begin
         exp_dout = b;
         check({tag, ".byte"}, dv_bytes[dv_bytes.size() - 1], b);
      end
      check({tag, ".data_out"}, bus.data_out, exp_dout);
      check({tag, ".busy"}, bus.busy, 1'b0);
   endtask

   task automatic send_frame(input string tag, input logic [7:0] b, input logic p,
                             input logic s, input int glitch);
      snap();
      drive_bits(make_frame(b, p, s), 0, 10, glitch);
      expect_frame(tag, b, p, s);
   endtask

   initial begin
      logic [7:0] rb;
      logic [1:0] mode;

      rst         = 1'b1;
      bus.ps2clk  = 1'b1;
      bus.ps2data = 1'b1;
      exp_dout    = 8'h00;
      idle(5);
      check("rst.data_out", bus.data_out, 8'h00);
      check("rst.dv", bus.data_valid, 1'b0);
      check("rst.pe", bus.parity_err, 1'b0);
      check("rst.fe", bus.frame_err, 1'b0);
      check("rst.busy", bus.busy, 1'b0);
      rst = 1'b0;
      idle(20);

      // Good 0x1C, with latency from the stop-bit fall
      send_frame("good1c", 8'h1C, 1'b0, 1'b1, -1);
      check_range("good1c.latency", dv_cyc - fall_cyc, F + 1, F + 6);

      send_frame("badpar", 8'h1C, 1'b1, 1'b1, -1);
      send_frame("badstop", 8'hF0, 1'b1, 1'b0, -1);

      // Timeout after start + 5 data bits
      snap();
      drive_bits(make_frame(8'h55, good_par(8'h55), 1'b1), 0, 5, -1);
      idle(HALF);
      check("tmo.busy_mid", bus.busy, 1'b1);
      idle(T + F + 20);
      check("tmo.fe", n_fe - b_fe, 1);
      check("tmo.dv", n_dv - b_dv, 0);
      check("tmo.pe", n_pe - b_pe, 0);
      check_range("tmo.when", fe_cyc - fall_cyc, T, T + F + 8);
      check("tmo.busy", bus.busy, 1'b0);
      check("tmo.data_out", bus.data_out, exp_dout);
      send_frame("after_tmo", 8'h1C, 1'b0, 1'b1, -1);

      // Short low glitch while idle with data low must not start a frame
      snap();
      bus.ps2data = 1'b0;
      idle(5);
      bus.ps2clk = 1'b0;
      idle(F - 1);
      bus.ps2clk = 1'b1;
      idle(30);
      check("glitch_idle.busy", bus.busy, 1'b0);
      check("glitch_idle.pulses", (n_dv - b_dv) + (n_pe - b_pe) + (n_fe - b_fe), 0);
      // A FILTER_LEN-cycle low pulse is a real start-bit edge
      bus.ps2clk = 1'b0;
      idle(F);
      bus.ps2clk = 1'b1;
      idle(HALF);
      check("edge_min.busy", bus.busy, 1'b1);
      drive_bits(make_frame(8'hA5, good_par(8'hA5), 1'b1), 1, 10, -1);
      expect_frame("edge_min", 8'hA5, good_par(8'hA5), 1'b1);

      // Glitch with inverted data inside the data phase
      send_frame("glitch_data", 8'h3C, good_par(8'h3C), 1'b1, 4);

      // Back-to-back frames
      snap();
      drive_bits(make_frame(8'hF0, good_par(8'hF0), 1'b1), 0, 10, -1);
      drive_bits(make_frame(8'h1C, good_par(8'h1C), 1'b1), 0, 10, -1);
      idle(40);
      check("b2b.count", n_dv - b_dv, 2);
      check("b2b.first", dv_bytes[dv_bytes.size() - 2], 8'hF0);
      check("b2b.second", dv_bytes[dv_bytes.size() - 1], 8'h1C);
      exp_dout = 8'h1C;

      // Reset during bit 4 of a third frame
      snap();
      drive_bits(make_frame(8'h99, good_par(8'h99), 1'b1), 0, 4, -1);
      @(negedge clk);
      bus.ps2data = 1'b1;
      rst = 1'b1;
      idle(3);
      check("midrst.data_out", bus.data_out, 8'h00);
      check("midrst.busy", bus.busy, 1'b0);
      rst = 1'b0;
      idle(30);
      check("midrst.pulses", (n_dv - b_dv) + (n_pe - b_pe) + (n_fe - b_fe), 0);
      check("midrst.busy_after", bus.busy, 1'b0);
      exp_dout = 8'h00;
      send_frame("after_rst", 8'h6E, good_par(8'h6E), 1'b1, -1);

      // Random frames with random corruption
      for (int k = 0; k < 8; k++) begin
         rb   = 8'($urandom);
         mode = 2'($urandom_range(0, 3));
         send_frame("rand", rb, good_par(rb) ^ mode[0], ~mode[1], -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
